// File: rtl/ofb_d_seq.sv
// ofb_d_seq: sequential AES-128 OFB-mode decryptor.
//
// A single iterative AES round engine produces the keystream. It runs one
// round per clock and expands the round keys on the fly. Each finished
// keystream block is re-encrypted to give the next one (OFB chaining). Each
// accepted ciphertext block is XORed with the current keystream block to
// recover the image block. The block is its own inverse: feeding plaintext
// yields ciphertext.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   start, key, iv      one-cycle pulse that samples key/iv and begins a stream
//   in_valid, in_ready  ciphertext handshake
//   ciphertext          ciphertext block, byte 1 in [128:121]
//   out_valid, out_ready image handshake
//   image               recovered block (registered)
//   pre_enc_res         current keystream block (registered)
//   blk_cnt             ciphertext blocks accepted since the last start
//   busy                high while the round engine runs
module ofb_d_seq (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [128:1]  key,
    input  logic [128:1]  iv,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [128:1]  ciphertext,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [128:1]  image,
    output logic [128:1]  pre_enc_res,
    output logic [32:1]   blk_cnt,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, GEN, READY} state_t;

    state_t        state, state_nxt;
    logic [128:1]  st, rk, key_store;
    logic [3:0]    round;
    logic [128:1]  next_rk, round_out;
    logic          accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (b^254, with 0 mapping to 0) followed by the
    // AES affine transform; this avoids a hand-typed 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv, sq;
        inv = 8'h01;
        sq  = b;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, sq);
            sq = gmul(sq, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [128:1] key_expand(input logic [128:1] k, input logic [7:0] rc);
        logic [32:1] w0, w1, w2, w3, t, n0, n1, n2, n3;
        {w0, w1, w2, w3} = k;
        // RotWord then SubWord on the last word, then the round constant
        t  = {sbox(w3[24:17]), sbox(w3[16:9]), sbox(w3[8:1]), sbox(w3[32:25])}
             ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // State byte n (column n/4, row n%4) lives at [128-8n -: 8].
    function automatic logic [128:1] aes_round(input logic [128:1] s,
                                               input logic [128:1] k,
                                               input logic         last);
        logic [128:1] sb, sr, mc;
        logic [7:0]   a0, a1, a2, a3;
        sb = '0;
        sr = '0;
        mc = '0;
        for (int n = 0; n < 16; n++)
            sb[128-8*n -: 8] = sbox(s[128-8*n -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[128-8*(4*c+r) -: 8] = sb[128-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[128-32*c    -: 8];
            a1 = sr[128-32*c-8  -: 8];
            a2 = sr[128-32*c-16 -: 8];
            a3 = sr[128-32*c-24 -: 8];
            mc[128-32*c    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[128-32*c-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[128-32*c-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[128-32*c-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return (last ? sr : mc) ^ k;
    endfunction

    assign next_rk   = key_expand(rk, rcon(round));
    assign round_out = aes_round(st, next_rk, round == 4'd10);
    assign in_ready  = (state == READY) && !out_valid;
    assign busy      = (state == GEN);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = GEN;
        end else begin
            case (state)
                GEN:     if (round == 4'd10) state_nxt = READY;
                READY:   if (accept) state_nxt = GEN;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st          <= '0;
            rk          <= '0;
            round       <= '0;
            key_store   <= '0;
            image       <= '0;
            pre_enc_res <= '0;
            blk_cnt     <= '0;
            out_valid   <= 1'b0;
        end else if (start) begin
            // Restart discards any in-flight keystream and pending output.
            st        <= iv ^ key;
            rk        <= key;
            round     <= 4'd1;
            key_store <= key;
            out_valid <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            if (state == GEN) begin
                st    <= round_out;
                rk    <= next_rk;
                round <= round + 4'd1;
                if (round == 4'd10) pre_enc_res <= round_out;
            end else if (accept) begin
                // Re-encrypt the keystream block to get the next one.
                st      <= pre_enc_res ^ key_store;
                rk      <= key_store;
                round   <= 4'd1;
                image   <= ciphertext ^ pre_enc_res;
                blk_cnt <= blk_cnt + 32'd1;
            end
            // accept requires out_valid low, so set and clear never collide.
            if (accept)                      out_valid <= 1'b1;
            else if (out_valid && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ofb_d_seq.sv
// Directed testbench for ofb_d_seq using NIST SP800-38A OFB-AES128 and
// FIPS-197 vectors.
module tb_ofb_d_seq;

    logic          clk = 1'b0;
    logic          rst_n, start, in_valid, out_ready;
    logic [128:1]  key, iv, ciphertext;
    logic          in_ready, out_valid, busy;
    logic [128:1]  image, pre_enc_res;
    logic [32:1]   blk_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [128:1] NKEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [128:1] NIV  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [128:1] KS1  = 128'h50fe67cc996d32b6da0937e99bafec60;
    localparam logic [128:1] CT1  = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
    localparam logic [128:1] CT2  = 128'h7789508d16918f03f53c52dac54ed825;
    localparam logic [128:1] CT3  = 128'h9740051e9c5fecf64344f7a82260edcc;
    localparam logic [128:1] CT4  = 128'h304c6528f659c77866a510d9c1d6ae5e;
    localparam logic [128:1] PT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [128:1] PT2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [128:1] PT3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [128:1] PT4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [128:1] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [128:1] FIV  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [128:1] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    ofb_d_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .iv(iv),
        .in_valid(in_valid), .in_ready(in_ready), .ciphertext(ciphertext),
        .out_valid(out_valid), .out_ready(out_ready), .image(image),
        .pre_enc_res(pre_enc_res), .blk_cnt(blk_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [128:1] k, input logic [128:1] v);
        key = k; iv = v; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!in_ready && cnt < 40) begin
            tick();
            cnt++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: in_ready=%b after %0d cycles, required 1", in_ready, cnt);
        end
    endtask

    task automatic send(input logic [128:1] ct);
        in_valid = 1'b1; ciphertext = ct;
        tick();
        in_valid = 1'b0; ciphertext = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; key = NKEY; iv = NIV;
        tick(); tick();
        start = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready/out_valid/busy=%b required 000", {in_ready, out_valid, busy});
        end
        checks++;
        if (image !== '0 || pre_enc_res !== '0 || blk_cnt !== '0) begin
            errors++;
            $display("FAIL reset_data: image=%h pre=%h cnt=%0d required zeros", image, pre_enc_res, blk_cnt);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: busy=%b required 0", busy);
        end
    endtask

    task automatic test_single();
        int cnt;
        out_ready = 1'b1;
        do_start(NKEY, NIV);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: busy=%b required 1", busy);
        end
        wait_ready(cnt);
        // start cycle counts as cycle 0; in_ready high in cycle 11
        checks++;
        if (cnt != 10) begin
            errors++;
            $display("FAIL single_latency: edges after start=%0d required 10", cnt);
        end
        checks++;
        if (pre_enc_res !== KS1) begin
            errors++;
            $display("FAIL single_keystream: got %h required %h", pre_enc_res, KS1);
        end
        send(CT1);
        checks++;
        if (image !== PT1 || out_valid !== 1'b1 || blk_cnt !== 32'd1) begin
            errors++;
            $display("FAIL single_image: got %h v=%b cnt=%0d required %h v=1 cnt=1", image, out_valid, blk_cnt, PT1);
        end
    endtask

    task automatic test_chain();
        int cnt;
        logic [128:1] cts [3];
        logic [128:1] pts [3];
        cts = '{CT2, CT3, CT4};
        pts = '{PT2, PT3, PT4};
        for (int i = 0; i < 3; i++) begin
            wait_ready(cnt);
            send(cts[i]);
            checks++;
            if (image !== pts[i]) begin
                errors++;
                $display("FAIL chain_block%0d: got %h required %h", i + 2, image, pts[i]);
            end
        end
        checks++;
        if (blk_cnt !== 32'd4) begin
            errors++;
            $display("FAIL chain_count: got %0d required 4", blk_cnt);
        end
    endtask

    task automatic test_backpressure();
        int cnt;
        out_ready = 1'b1;
        do_start(NKEY, NIV);
        wait_ready(cnt);
        out_ready = 1'b0;
        send(CT1);
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (image !== PT1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: image=%h v=%b rdy=%b required %h v=1 rdy=0", i, image, out_valid, in_ready, PT1);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_gen_done: busy=%b required 0", busy);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
        end
        send(CT2);
        checks++;
        if (image !== PT2 || blk_cnt !== 32'd2) begin
            errors++;
            $display("FAIL bp_block2: got %h cnt=%0d required %h cnt=2", image, blk_cnt, PT2);
        end
    endtask

    task automatic test_restart();
        int cnt;
        out_ready = 1'b1;
        do_start(NKEY, NIV);
        wait_ready(cnt);
        out_ready = 1'b0;
        send(CT1);
        repeat (5) tick();
        do_start(FKEY, FIV);
        checks++;
        if (out_valid !== 1'b0 || blk_cnt !== 32'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: v=%b cnt=%0d busy=%b required 0 0 1", out_valid, blk_cnt, busy);
        end
        checks++;
        if (pre_enc_res !== KS1) begin
            errors++;
            $display("FAIL restart_no_leak: pre=%h required %h", pre_enc_res, KS1);
        end
        out_ready = 1'b1;
        wait_ready(cnt);
        checks++;
        if (cnt != 10 || pre_enc_res !== FCT) begin
            errors++;
            $display("FAIL restart_keystream: got %h after %0d required %h after 10", pre_enc_res, cnt, FCT);
        end
        send('0);
        checks++;
        if (image !== FCT || blk_cnt !== 32'd1) begin
            errors++;
            $display("FAIL restart_image: got %h cnt=%0d required %h cnt=1", image, blk_cnt, FCT);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        out_ready = 1'b1;
        do_start(NKEY, NIV);
        wait_ready(cnt);
        out_ready = 1'b0;
        send(CT1);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000 || image !== '0 || pre_enc_res !== '0 || blk_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid: rdy/v/busy=%b image=%h pre=%h cnt=%0d required zeros", {in_ready, out_valid, busy}, image, pre_enc_res, blk_cnt);
        end
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; ciphertext = CT1;
        repeat (12) tick();
        in_valid = 1'b0;
        checks++;
        if (blk_cnt !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ignore: cnt=%0d v=%b busy=%b rdy=%b required 0 0 0 0", blk_cnt, out_valid, busy, in_ready);
        end
    endtask

    task automatic test_ignored();
        in_valid = 1'b1; ciphertext = CT1;
        repeat (5) tick();
        checks++;
        if (blk_cnt !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignored_idle: cnt=%0d v=%b required 0 0", blk_cnt, out_valid);
        end
        do_start(NKEY, NIV);
        repeat (5) tick();
        checks++;
        if (blk_cnt !== '0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ignored_gen: cnt=%0d v=%b busy=%b required 0 0 1", blk_cnt, out_valid, busy);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; key = '0; iv = '0;
        in_valid = 1'b0; ciphertext = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_chain();
        test_backpressure();
        test_restart();
        test_reset_mid();
        test_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofb_d_seq.md
# ofb_d_seq

Sequential AES-128 OFB-mode decryptor. It is the receive-side counterpart of the combinational OFB encryptor and recovers image blocks from a stream of ciphertext blocks. A single iterative round engine generates the keystream, one AES round per clock. Each keystream block is fed back as the input for the next block, as OFB chaining requires. The block sits between the ciphertext source and the image sink, with valid/ready handshakes on both sides.

## Interface
No parameters. Fixed to AES-128, 10 rounds.

- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse; samples key and iv and begins a new stream
- key  input  [128:1]  cipher key; sampled only when start is high
- iv  input  [128:1]  initialisation vector; sampled only when start is high
- in_valid  input  1  ciphertext block is present
- in_ready  output  1  block accepts ciphertext this cycle
- ciphertext  input  [128:1]  ciphertext block; byte 1 is in [128:121]
- out_valid  output  1  image holds a recovered block
- out_ready  input  1  sink accepts image this cycle
- image  output  [128:1]  recovered image block, registered
- pre_enc_res  output  [128:1]  current keystream block, registered
- blk_cnt  output  [32:1]  count of ciphertext blocks accepted since the last start
- busy  output  1  high in GEN

## Operation
- FSM states: IDLE, GEN, READY.
- In IDLE, the block waits for start.
- GEN runs one AES round per cycle. Rounds 1–9 apply SubBytes, ShiftRows, MixColumns and AddRoundKey. Round 10 omits MixColumns.
- Round keys are produced on the fly from a 128-bit rk register. next_rk = expand(rk, rcon[round]), with rcon = 01,02,04,08,10,20,40,80,1b,36.
- round is a 4-bit counter running 1..10.
- Registered state: st[128] (AES state), rk[128], round[4], stored key[128].
- On start (any state):
  - st ← iv ^ key, rk ← key, round ← 1, stored key ← key.
  - State goes to GEN. out_valid ← 0 and blk_cnt ← 0.
  - Any in-flight block or pending output is discarded.
- Each GEN cycle: st ← round(st, next_rk), rk ← next_rk, round ← round+1.
  - After round 10: pre_enc_res ← result, state goes to READY.
- in_ready = (state==READY) && !out_valid.
- Accept = in_valid && in_ready. On accept:
  - image ← ciphertext ^ pre_enc_res, out_valid ← 1, blk_cnt ← blk_cnt+1 (wraps modulo 2^32).
  - st ← pre_enc_res ^ stored key, rk ← stored key, round ← 1, state goes to GEN.
- out_valid clears on the edge where out_ready is high. While out_ready is low, image holds steady.
- Output drain is independent of GEN. A pending output does not stall keystream generation; it only blocks the next accept.
- in_valid outside READY is ignored, and ciphertext is not sampled.
- Decryption is XOR with the keystream, so feeding plaintext yields ciphertext. The block is self-inverse.

## Timing
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - in_ready=0, out_valid=0, busy=0.
  - image=0, pre_enc_res=0, blk_cnt=0.
  - st, rk and round are cleared.
- Reset has priority over start. start has priority over accept.
- Latency:
  - start sampled at edge T: GEN during cycles T+1..T+10, pre_enc_res valid and in_ready high from the cycle after edge T+10.
  - Accept at edge E: out_valid high from E+1.
  - Next keystream ready after edge E+10.
- Throughput: at most 1 block per 11 cycles.
- Output stall: if out_valid is still high when GEN finishes, in_ready stays low. It rises the cycle after the out_ready handshake.
- start during GEN restarts the round counter at 1. No partial result leaks to pre_enc_res.
- start asserted while rst_n is low is ignored.

## Test plan
- Single block, NIST SP800-38A OFB-AES128 block 1:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102030405060708090a0b0c0d0e0f, start, then ciphertext 3b3fd92eb72dad20333449f8e83cfb4a with out_ready=1.
  - Required: in_ready rises exactly 11 cycles after start; pre_enc_res = 50fe67cc996d32b6da0937e99bafec60; image = 6bc1bee22e409f96e93d7e117393172a.
- Chaining, blocks 2–4 of the same vector:
  - Stimulus: 7789508d16918f03f53c52dac54ed825, 9740051e9c5fecf64344f7a82260edcc, 304c6528f659c77866a510d9c1d6ae5e.
  - Required: image = ae2d8a571e03ac9c9eb76fac45af8e51, 30c81c46a35ce411e5fbc1191a0a52ef, f69f2445df4f9b17ad2b417be66c3710; blk_cnt=4.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after block 1.
  - Required: image stable; in_ready stays low after GEN completes; block 2 is accepted only after the handshake and decrypts correctly.
- Restart mid-GEN:
  - Stimulus: start with the FIPS-197 key 000102…0f and iv 00112233445566778899aabbccddeeff, 5 cycles into block-2 generation; feed all-zero ciphertext.
  - Required: pre_enc_res and image = 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid cleared at restart; blk_cnt=1.
- Reset mid-operation:
  - Stimulus: rst_n low during GEN with out_valid=1.
  - Required: all outputs zero next cycle; in_valid ignored until a new start.
- Ignored input:
  - Stimulus: in_valid=1 during GEN and in IDLE.
  - Required: no accept; blk_cnt unchanged.
